// File: rtl/ask_link_pkg.sv
// Shared widths, noise-mode encodings and FSM state encoding for the ASK link scheduler.
package ask_link_pkg;

  localparam int NIBBLE_W = 4;
  localparam int NOISE_W  = 5;
  localparam int FREQ_W   = 16;

  // Mode 3 is reserved and behaves like NOISE_NONE.
  localparam logic [1:0] NOISE_NONE  = 2'd0;
  localparam logic [1:0] NOISE_FIXED = 2'd1;
  localparam logic [1:0] NOISE_WALK  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_CAPTURE   = 3'd5,
    ST_OUT       = 3'd6
  } link_state_e;

endpackage

// File: rtl/ask_link_scheduler_if.sv
// Payload-in and result-out valid/ready streams of the link scheduler.
interface ask_link_scheduler_if;
  import ask_link_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [NIBBLE_W-1:0] in_data;

  logic                out_valid;
  logic                out_ready;
  logic [NIBBLE_W-1:0] out_data;
  logic                out_err1;
  logic                out_err2;
  logic                out_errpar;
  logic                out_timeout;

  // Producer / consumer side (stimulus source and result sink).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err1, out_err2, out_errpar, out_timeout
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err1, out_err2, out_errpar, out_timeout
  );

endinterface

// File: rtl/link_stat_counters.sv
// Four saturating link-quality counters with a synchronous clear that beats increments.
module link_stat_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc_frame,
  input  logic             i_inc_corr,
  input  logic             i_inc_uncorr,
  input  logic             i_inc_timeout,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_corr_cnt,
  output logic [CNT_W-1:0] o_uncorr_cnt,
  output logic [CNT_W-1:0] o_timeout_cnt
);

  logic [CNT_W-1:0] r_frame;
  logic [CNT_W-1:0] r_corr;
  logic [CNT_W-1:0] r_uncorr;
  logic [CNT_W-1:0] r_timeout;

  // Count on strobe, stick at all-ones; clear takes priority over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame   <= '0;
      r_corr    <= '0;
      r_uncorr  <= '0;
      r_timeout <= '0;
    end else if (i_clr) begin
      r_frame   <= '0;
      r_corr    <= '0;
      r_uncorr  <= '0;
      r_timeout <= '0;
    end else begin
      if (i_inc_frame   && (r_frame   != '1)) r_frame   <= r_frame   + 1'b1;
      if (i_inc_corr    && (r_corr    != '1)) r_corr    <= r_corr    + 1'b1;
      if (i_inc_uncorr  && (r_uncorr  != '1)) r_uncorr  <= r_uncorr  + 1'b1;
      if (i_inc_timeout && (r_timeout != '1)) r_timeout <= r_timeout + 1'b1;
    end
  end

  assign o_frame_cnt   = r_frame;
  assign o_corr_cnt    = r_corr;
  assign o_uncorr_cnt  = r_uncorr;
  assign o_timeout_cnt = r_timeout;

endmodule

// File: rtl/ask_link_scheduler.sv
// Frame sequencer for the SECDED + ASK link datapath: loads one nibble, runs the
// datapath, waits for done (or times out), settles, captures and hands back the result.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | in_ready high, waiting for a payload nibble
//   LOAD      | latch carrier word and noise vector for this frame
//   START     | dp_start held START_HOLD cycles, any dp_done remembered
//   WAIT_DONE | waiting for dp_done, abandon frame after TIMEOUT_CYC cycles
//   SETTLE    | SETTLE_CYC cycles for the decoder outputs to settle
//   CAPTURE   | register decoded nibble and flags, bump statistics
//   OUT       | out_valid high until the consumer takes the result
module ask_link_scheduler
  import ask_link_pkg::*;
#(
  parameter int START_HOLD  = 45,
  parameter int SETTLE_CYC  = 30,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ask_link_scheduler_if.slave lnk,
  input  logic [1:0]          noise_mode,
  input  logic [NOISE_W-1:0]  noise_pat,
  input  logic [FREQ_W-1:0]   freq_cfg,
  output logic                dp_start,
  output logic [NIBBLE_W-1:0] dp_data,
  output logic [NOISE_W-1:0]  dp_noise,
  output logic [FREQ_W-1:0]   dp_freq,
  input  logic [NIBBLE_W-1:0] dp_data_o,
  input  logic                dp_error1bit,
  input  logic                dp_error2bit,
  input  logic                dp_errorparity,
  input  logic                dp_done,
  output logic                busy,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    corr_cnt,
  output logic [CNT_W-1:0]    uncorr_cnt,
  output logic [CNT_W-1:0]    timeout_cnt
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_LOAD    = ST_LOAD;
  localparam logic [2:0] S_START   = ST_START;
  localparam logic [2:0] S_WAIT    = ST_WAIT_DONE;
  localparam logic [2:0] S_SETTLE  = ST_SETTLE;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_OUT     = ST_OUT;

  localparam int HOLD_W = (START_HOLD  > 1) ? $clog2(START_HOLD)  : 1;
  localparam int SET_W  = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
  localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // With no settle time the frame goes straight from done to capture.
  localparam logic [2:0] S_AFTER_DONE = (SETTLE_CYC == 0) ? S_CAPTURE : S_SETTLE;

  logic [2:0]          r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic [SET_W-1:0]    r_settle;
  logic [TO_W-1:0]     r_tout;
  logic                r_done_seen;
  logic [2:0]          r_walk;
  logic [NIBBLE_W-1:0] r_dp_data;
  logic [NOISE_W-1:0]  r_dp_noise;
  logic [FREQ_W-1:0]   r_dp_freq;
  logic [NIBBLE_W-1:0] r_out_data;
  logic                r_out_err1;
  logic                r_out_err2;
  logic                r_out_errpar;
  logic                r_out_timeout;

  logic w_capture;
  logic w_timeout;

  assign w_capture = (r_state == S_CAPTURE);
  assign w_timeout = (r_state == S_WAIT) && !dp_done && (r_tout == TO_W'(TIMEOUT_CYC - 1));

  // Frame sequencing, datapath operand latching and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_settle      <= '0;
      r_tout        <= '0;
      r_done_seen   <= 1'b0;
      r_dp_data     <= '0;
      r_dp_noise    <= '0;
      r_dp_freq     <= '0;
      r_out_data    <= '0;
      r_out_err1    <= 1'b0;
      r_out_err2    <= 1'b0;
      r_out_errpar  <= 1'b0;
      r_out_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lnk.in_valid) begin
            r_dp_data <= lnk.in_data;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_dp_freq <= freq_cfg;
          case (noise_mode)
            NOISE_NONE:  r_dp_noise <= '0;
            NOISE_FIXED: r_dp_noise <= noise_pat;
            NOISE_WALK:  r_dp_noise <= NOISE_W'(1) << r_walk;
            default:     r_dp_noise <= '0;
          endcase
          r_hold      <= HOLD_W'(START_HOLD - 1);
          r_done_seen <= 1'b0;
          r_state     <= S_START;
        end
        S_START: begin
          if (r_hold == '0) begin
            r_settle <= SET_W'(SETTLE_CYC - 1);
            r_tout   <= '0;
            r_state  <= (r_done_seen || dp_done) ? S_AFTER_DONE : S_WAIT;
          end else begin
            r_hold      <= r_hold - 1'b1;
            r_done_seen <= r_done_seen | dp_done;
          end
        end
        S_WAIT: begin
          if (dp_done) begin
            r_settle <= SET_W'(SETTLE_CYC - 1);
            r_state  <= S_AFTER_DONE;
          end else if (w_timeout) begin
            r_out_data    <= '0;
            r_out_err1    <= 1'b0;
            r_out_err2    <= 1'b0;
            r_out_errpar  <= 1'b0;
            r_out_timeout <= 1'b1;
            r_state       <= S_OUT;
          end else begin
            r_tout <= r_tout + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) r_state <= S_CAPTURE;
          else                r_settle <= r_settle - 1'b1;
        end
        S_CAPTURE: begin
          r_out_data    <= dp_data_o;
          r_out_err1    <= dp_error1bit;
          r_out_err2    <= dp_error2bit;
          r_out_errpar  <= dp_errorparity;
          r_out_timeout <= 1'b0;
          r_state       <= S_OUT;
        end
        S_OUT: begin
          if (lnk.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Walking-bit index advances after each walk-mode LOAD; a counter clear rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_walk <= '0;
    end else if (cnt_clr) begin
      r_walk <= '0;
    end else if ((r_state == S_LOAD) && (noise_mode == NOISE_WALK)) begin
      r_walk <= (r_walk == 3'd4) ? 3'd0 : r_walk + 3'd1;
    end
  end

  link_stat_counters #(.CNT_W(CNT_W)) u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (cnt_clr),
    .i_inc_frame   (w_capture | w_timeout),
    .i_inc_corr    (w_capture & dp_error1bit & ~dp_error2bit),
    .i_inc_uncorr  (w_capture & dp_error2bit),
    .i_inc_timeout (w_timeout),
    .o_frame_cnt   (frame_cnt),
    .o_corr_cnt    (corr_cnt),
    .o_uncorr_cnt  (uncorr_cnt),
    .o_timeout_cnt (timeout_cnt)
  );

  assign lnk.in_ready    = (r_state == S_IDLE);
  assign lnk.out_valid   = (r_state == S_OUT);
  assign lnk.out_data    = r_out_data;
  assign lnk.out_err1    = r_out_err1;
  assign lnk.out_err2    = r_out_err2;
  assign lnk.out_errpar  = r_out_errpar;
  assign lnk.out_timeout = r_out_timeout;

  assign dp_start = (r_state == S_START);
  assign dp_data  = r_dp_data;
  assign dp_noise = r_dp_noise;
  assign dp_freq  = r_dp_freq;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ask_link_scheduler.sv
// Scoreboard bench for ask_link_scheduler: directed frames push expected results,
// a negedge monitor pops and compares on every accepted output.
module tb_ask_link_scheduler;

  typedef struct packed {
    logic [3:0] d;
    logic       e1;
    logic       e2;
    logic       ep;
    logic       to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic        out_ready = 1'b1;
  logic [1:0]  noise_mode = '0;
  logic [4:0]  noise_pat = '0;
  logic [15:0] freq_cfg = '0;
  logic        cnt_clr = 1'b0;
  logic        dp_done = 1'b0;
  logic        m_err1 = 1'b0, m_err2 = 1'b0, m_par = 1'b0;

  logic        a_dp_start, b_dp_start, a_busy, b_busy;
  logic [3:0]  a_dp_data, b_dp_data;
  logic [4:0]  a_dp_noise, b_dp_noise;
  logic [15:0] a_dp_freq, b_dp_freq;
  logic [15:0] a_frame, a_corr, a_uncorr, a_tout;
  logic [1:0]  b_frame, b_corr, b_uncorr, b_tout;

  int   n_pass = 0, n_chk = 0, n_out = 0, n_pushed = 0;
  exp_t sb_q[$];

  int   dm_cyc = -1;
  int   dm_done_at = 50;
  logic dm_prev = 1'b0;

  ask_link_scheduler_if ifa();
  ask_link_scheduler_if ifb();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  ask_link_scheduler #(.TIMEOUT_CYC(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .lnk(ifa),
    .noise_mode(noise_mode), .noise_pat(noise_pat), .freq_cfg(freq_cfg),
    .dp_start(a_dp_start), .dp_data(a_dp_data), .dp_noise(a_dp_noise), .dp_freq(a_dp_freq),
    .dp_data_o(a_dp_data), .dp_error1bit(m_err1), .dp_error2bit(m_err2),
    .dp_errorparity(m_par), .dp_done(dp_done), .busy(a_busy), .cnt_clr(cnt_clr),
    .frame_cnt(a_frame), .corr_cnt(a_corr), .uncorr_cnt(a_uncorr), .timeout_cnt(a_tout)
  );

  ask_link_scheduler #(.TIMEOUT_CYC(64), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .lnk(ifb),
    .noise_mode(noise_mode), .noise_pat(noise_pat), .freq_cfg(freq_cfg),
    .dp_start(b_dp_start), .dp_data(b_dp_data), .dp_noise(b_dp_noise), .dp_freq(b_dp_freq),
    .dp_data_o(b_dp_data), .dp_error1bit(m_err1), .dp_error2bit(m_err2),
    .dp_errorparity(m_par), .dp_done(dp_done), .busy(b_busy), .cnt_clr(cnt_clr),
    .frame_cnt(b_frame), .corr_cnt(b_corr), .uncorr_cnt(b_uncorr), .timeout_cnt(b_tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired, event not seen", nm);
  endtask

  function automatic exp_t mk(input logic [3:0] d, input logic e1, input logic e2,
                              input logic ep, input logic to);
    exp_t e;
    e = '{d: d, e1: e1, e2: e2, ep: ep, to: to};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Datapath model: done pulses dm_done_at cycles after dp_start rises (-1 = never).
  initial forever begin
    @(posedge clk);
    #1;
    if (a_dp_start && !dm_prev) dm_cyc = 0;
    else if (dm_cyc >= 0) dm_cyc++;
    dm_prev = a_dp_start;
    dp_done = (dm_done_at >= 0) && (dm_cyc == dm_done_at);
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && ifa.out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got data 0x%0h with empty scoreboard, want no output",
                 ifa.out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_data",    32'(ifa.out_data),    32'(e.d));
        chk("out_err1",    32'(ifa.out_err1),    32'(e.e1));
        chk("out_err2",    32'(ifa.out_err2),    32'(e.e2));
        chk("out_errpar",  32'(ifa.out_errpar),  32'(e.ep));
        chk("out_timeout", 32'(ifa.out_timeout), 32'(e.to));
        chk("b_out_data",  32'(ifb.out_data),    32'(e.d));
      end
    end
  end

  task automatic send(input logic [3:0] nib, input bit push, input exp_t e);
    int k;
    in_valid = 1'b1;
    in_data  = nib;
    k = 0;
    while (!ifa.in_ready && k < 5000) begin
      tick();
      k++;
    end
    if (!ifa.in_ready) bound_fail("send_accept");
    if (push) begin
      sb_q.push_back(e);
      n_pushed++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (a_busy && k < 20000) begin
      tick();
      k++;
    end
    if (a_busy) bound_fail(nm);
  endtask

  initial begin
    logic [4:0] walk_exp [6];
    int k;
    walk_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(ifa.in_ready),    32'd1);
    chk("rst_out_valid", 32'(ifa.out_valid),   32'd0);
    chk("rst_dp_start",  32'(a_dp_start),      32'd0);
    chk("rst_busy",      32'(a_busy),          32'd0);
    chk("rst_timeout",   32'(ifa.out_timeout), 32'd0);
    chk("rst_frame_cnt", 32'(a_frame),         32'd0);
    rst_n = 1'b1;
    tick();

    // Reset while waiting for done: frame lost, nothing counted.
    dm_done_at = -1;
    noise_mode = 2'd1; noise_pat = 5'h0a; freq_cfg = 16'h1234;
    send(4'h5, 1'b0, mk(0, 0, 0, 0, 0));
    repeat (56) tick();
    chk("wait_busy",     32'(a_busy),     32'd1);
    chk("wait_dp_start", 32'(a_dp_start), 32'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mrst_dp_start",  32'(a_dp_start),   32'd0);
    chk("mrst_in_ready",  32'(ifa.in_ready), 32'd1);
    chk("mrst_frame_cnt", 32'(a_frame),      32'd0);

    // Mode 1, nibbles 0..15, datapath reports a corrected single-bit error.
    noise_mode = 2'd1; noise_pat = 5'b00001; freq_cfg = 16'd4096;
    dm_done_at = 50; m_err1 = 1'b1; m_err2 = 1'b0; m_par = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b1, mk(4'(i), 1'b1, 1'b0, 1'b1, 1'b0));
      if (i == 0) begin
        tick();
        chk("m1_dp_noise", 32'(a_dp_noise), 32'h01);
        chk("m1_dp_freq",  32'(a_dp_freq),  32'd4096);
        chk("m1_dp_data",  32'(a_dp_data),  32'd0);
      end
      wait_idle("m1_frame_done");
    end
    chk("m1_frame_cnt", 32'(a_frame),  32'd16);
    chk("m1_corr_cnt",  32'(a_corr),   32'd16);
    chk("m1_uncorr",    32'(a_uncorr), 32'd0);
    chk("b_corr_sat",   32'(b_corr),   32'd3);
    chk("b_frame_sat",  32'(b_frame),  32'd3);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_frame", 32'(a_frame), 32'd0);
    chk("clr_corr",  32'(a_corr),  32'd0);
    chk("clr_b_corr", 32'(b_corr), 32'd0);

    // Mode 2 walking bit, uncorrectable errors reported.
    noise_mode = 2'd2; dm_done_at = 3;
    m_err1 = 1'b1; m_err2 = 1'b1; m_par = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(4'(i + 3), 1'b1, mk(4'(i + 3), 1'b1, 1'b1, 1'b0, 1'b0));
      tick();
      chk("walk_noise", 32'(a_dp_noise), 32'(walk_exp[i]));
      wait_idle("walk_frame_done");
    end
    chk("walk_uncorr", 32'(a_uncorr), 32'd6);
    chk("walk_corr",   32'(a_corr),   32'd0);
    chk("walk_frame",  32'(a_frame),  32'd6);

    // Reserved mode gives no noise; config changes mid-frame are ignored.
    noise_mode = 2'd3; freq_cfg = 16'h0101;
    send(4'h9, 1'b1, mk(4'h9, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    chk("m3_noise", 32'(a_dp_noise), 32'd0);
    noise_mode = 2'd1; noise_pat = 5'h1f; freq_cfg = 16'hffff;
    repeat (5) tick();
    chk("mid_noise", 32'(a_dp_noise), 32'd0);
    chk("mid_freq",  32'(a_dp_freq),  32'h0101);
    wait_idle("m3_frame_done");

    // Datapath never finishes: timeout 64 cycles after WAIT_DONE entry.
    dm_done_at = -1;
    send(4'hc, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    k = 0;
    while (!a_dp_start && k < 100) begin tick(); k++; end
    k = 0;
    while (a_dp_start && k < 100) begin tick(); k++; end
    k = 0;
    while (!ifa.out_valid && k < 200) begin tick(); k++; end
    chk("timeout_latency", 32'(k), 32'd64);
    wait_idle("timeout_frame_done");
    chk("timeout_cnt",       32'(a_tout),  32'd1);
    chk("timeout_frame_cnt", 32'(a_frame), 32'd8);

    // Done pulse inside START: no WAIT_DONE, output after hold + settle.
    dm_done_at = 10; m_err1 = 1'b1; m_err2 = 1'b0; m_par = 1'b1;
    send(4'h6, 1'b1, mk(4'h6, 1'b1, 1'b0, 1'b1, 1'b0));
    tick();
    chk("pulse_start", 32'(a_dp_start), 32'd1);
    k = 0;
    while (!ifa.out_valid && k < 300) begin tick(); k++; end
    chk("pulse_latency", 32'(k), 32'd76);
    wait_idle("pulse_frame_done");

    // Consumer stalls for 20 cycles.
    out_ready = 1'b0; dm_done_at = 3;
    m_err1 = 1'b0; m_err2 = 1'b0; m_par = 1'b0;
    send(4'ha, 1'b1, mk(4'ha, 1'b0, 1'b0, 1'b0, 1'b0));
    k = 0;
    while (!ifa.out_valid && k < 300) begin tick(); k++; end
    if (!ifa.out_valid) bound_fail("stall_out_valid");
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid",    32'(ifa.out_valid), 32'd1);
      chk("stall_data",     32'(ifa.out_data),  32'ha);
      chk("stall_in_ready", 32'(ifa.in_ready),  32'd0);
      tick();
    end
    chk("stall_frame_cnt", 32'(a_frame), 32'd10);
    out_ready = 1'b1;
    wait_idle("stall_frame_done");
    chk("stall_frame_after", 32'(a_frame), 32'd10);
    chk("stall_corr",        32'(a_corr),  32'd1);

    // Reset mid-START drops dp_start immediately.
    dm_done_at = -1;
    send(4'h3, 1'b0, mk(0, 0, 0, 0, 0));
    tick();
    chk("pre_rst_start", 32'(a_dp_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dp_start", 32'(a_dp_start),   32'd0);
    chk("async_in_ready", 32'(ifa.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("out_count",  32'(n_out),       32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ask_link_scheduler.md
Name: ask_link_scheduler

Overview:
- Frame sequencer for the Hamming SECDED + ASK link datapath (encoder → modulator → noise channel → demodulator → decoder).
- Accepts 4-bit payload nibbles over a valid/ready interface and, for each frame:
  - applies the frame's noise pattern and carrier frequency word;
  - pulses the datapath's start, waits for its done, then lets the decoder outputs settle;
  - returns the decoded nibble and error flags over a valid/ready output.
- Maintains saturating link-quality counters for BER sweeps.

Parameters:
- START_HOLD, 45, cycles dp_start is held high per frame (≥1)
- SETTLE_CYC, 30, cycles waited after done before capture (≥0)
- TIMEOUT_CYC, 4096, max cycles in WAIT_DONE before the frame is abandoned
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  payload nibble valid
- in_ready  out  1  scheduler can accept a nibble
- in_data  in  4  payload nibble
- noise_mode  in  2  0 = none, 1 = fixed noise_pat, 2 = walking single bit, 3 = reserved (treated as 0)
- noise_pat  in  5  fixed noise pattern for mode 1
- freq_cfg  in  16  carrier frequency word
- dp_start  out  1  datapath start
- dp_data  out  4  datapath payload (sedbec_in)
- dp_noise  out  5  datapath noise vector (noise1)
- dp_freq  out  16  datapath frequency word
- dp_data_o  in  4  decoded nibble
- dp_error1bit  in  1  single-bit corrected flag
- dp_error2bit  in  1  double-bit detected flag
- dp_errorparity  in  1  overall parity error flag
- dp_done  in  1  datapath done (level or pulse)
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_data  out  4  captured decoded nibble
- out_err1, out_err2, out_errpar  out  1 each  captured flags
- out_timeout  out  1  frame abandoned by timeout
- busy  out  1  high in any state except IDLE
- cnt_clr  in  1  synchronous clear of counters and walk index
- frame_cnt, corr_cnt, uncorr_cnt, timeout_cnt  out  CNT_W each  saturating statistics

Behaviour:
- Reset values:
  - all outputs 0 except in_ready = 1;
  - FSM state = IDLE; walk index = 0; hold/settle/timeout counters = 0.
- FSM states: IDLE, LOAD, START, WAIT_DONE, SETTLE, CAPTURE, OUT.
- IDLE:
  - in_ready = 1;
  - on in_valid&&in_ready, register in_data → dp_data and go to LOAD.
- LOAD (1 cycle):
  - latch dp_freq = freq_cfg;
  - latch dp_noise: mode 0/3 → 0; mode 1 → noise_pat; mode 2 → 5'b1 << idx.
  - dp_data, dp_noise and dp_freq stay stable until the next LOAD.
- START:
  - dp_start = 1 for exactly START_HOLD cycles;
  - a sticky done_seen flag captures any dp_done high during START;
  - after the hold: if done_seen → SETTLE, else → WAIT_DONE.
- WAIT_DONE:
  - dp_start = 0;
  - dp_done high → SETTLE;
  - timeout counter reaching TIMEOUT_CYC−1 without done → OUT with out_timeout = 1, out_data = 0, all error flags 0.
- SETTLE:
  - SETTLE_CYC cycles; with SETTLE_CYC = 0, SETTLE is skipped and the FSM goes straight to CAPTURE.
- CAPTURE (1 cycle):
  - register dp_data_o and the three error flags, out_timeout = 0;
  - update counters, then go to OUT.
- OUT:
  - out_valid = 1; outputs held stable while !out_ready;
  - on out_valid&&out_ready → IDLE, out_valid = 0 next cycle.
- Throughput:
  - in_ready is high only in IDLE;
  - minimum frame = 1 + 1 + START_HOLD + SETTLE_CYC + 1 + 1 cycles when done is already seen during START.
- Counters (each saturates at all-ones, never wraps):
  - frame_cnt +1 at each completed frame (CAPTURE or timeout);
  - corr_cnt +1 when error1bit && !error2bit;
  - uncorr_cnt +1 when error2bit;
  - timeout_cnt +1 on timeout.
- Walk index:
  - advances (4 → 0 wrap) at LOAD when mode = 2, after its value is used.
- cnt_clr:
  - zeroes all counters and the walk index next cycle; it does not disturb the FSM.
  - If cnt_clr coincides with a counter increment, the clear wins.
- noise_mode, noise_pat and freq_cfg changes mid-frame have no effect until the next LOAD.
- rst_n asserted mid-frame: immediate return to reset values, dp_start drops asynchronously, the in-flight frame is lost and not counted.

Decomposition:
- Package ask_link_pkg:
  - FSM state enum;
  - noise-mode constants (NOISE_NONE, NOISE_FIXED, NOISE_WALK);
  - NIBBLE_W = 4, NOISE_W = 5, FREQ_W = 16.
- Sub-module link_stat_counters: the four saturating counters with increment strobes and clear. All else stays in the FSM module.

Test Plan:
- Mode 1, noise_pat = 5'b00001, freq_cfg = 4096, nibbles 0..15 with out_ready = 1, datapath model returning the input with error1bit = 1 → each out_data = input, out_err1 = 1, out_err2 = 0; frame_cnt = 16, corr_cnt = 16.
- Mode 2, six frames → dp_noise sequence 00001, 00010, 00100, 01000, 10000, 00001.
- Datapath model never asserts done, TIMEOUT_CYC = 64 → out_timeout = 1 exactly 64 cycles after WAIT_DONE entry, timeout_cnt = 1, next nibble accepted normally.
- dp_done pulsed for 1 cycle at START cycle 10 → no WAIT_DONE entry; capture occurs START_HOLD + SETTLE_CYC cycles after START entry.
- out_ready held low 20 cycles → out_valid and out_data stable throughout, in_ready = 0; one frame counted, not re-counted.
- rst_n low for 3 cycles during WAIT_DONE → dp_start = 0 and in_ready = 1 after release; frame_cnt unchanged. CNT_W = 2 with 5 corrected frames → corr_cnt saturates at 3.
